residual_scan: RTL and testbench
================================

# residual_scan

Reads back the residual memory filled by the writeback stage of the matching pipeline. For every POI it finds the minimum residual over the 32×32 search window and its (row, column) location. Results are emitted one per POI on a valid/ready stream for the downstream stitching-offset logic. It is the read-side consumer of the residual store and is started by the pipeline's `done`/`status` pulse.

## Interface
Parameters:
- `POI_DEPTH`, default 4: log2 of POI rows.
- `POI_WIDTH`, default 4: log2 of POI columns.
- Window is fixed at 32 rows × 32 residuals of 8 bits. Row index is 5 bits, column index is 5 bits.
- Derived: `POI_AW = POI_DEPTH + POI_WIDTH`, `TOTAL_POI = 1 << POI_AW`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to scan all POIs.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `rd_en` out 1: residual memory read strobe.
- `rd_addr` out POI_AW+5: read address, `{poi, row}`.
- `rd_data` in 256: one window row. Residual column c is in `rd_data[8c+7:8c]`. The memory is synchronous with a read latency of exactly 1 cycle.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_poi` out POI_AW: POI index of the result.
- `res_row` out 5: window row of the minimum.
- `res_col` out 5: window column of the minimum.
- `res_min` out 8: minimum residual value.
- `done` out 1: one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, READ, DRAIN, EMIT.
- IDLE:
  - `start` high → READ, with poi=0 and row=0.
  - Accumulator initialised to min=0xFF, row=0, col=0.
- READ:
  - `rd_en`=1 every cycle with `rd_addr={poi,row}`. Row increments each cycle, rows 0..31.
  - After row 31 is issued → DRAIN.
- Row merge, in READ and DRAIN:
  - In the cycle after each read, the data is reduced combinationally to the row minimum and its lowest column index, then merged into the accumulator on that cycle's closing edge.
  - Merge uses strict less-than only, so a tie keeps the earlier entry: lowest row first, then lowest column.
- DRAIN: performs the final merge for row 31 → EMIT.
- EMIT:
  - `res_valid`=1. `res_poi`/`res_row`/`res_col`/`res_min` come from registers and stay stable while `res_ready`=0.
  - No reads are issued in EMIT.
  - On handshake (`res_valid`&&`res_ready`):
    - poi = TOTAL_POI−1 → IDLE and pulse `done`.
    - Otherwise poi+1, row=0, accumulator reinitialised → READ.
- Unsigned 8-bit compares only. An all-0xFF window returns min=0xFF at (0,0).
- `start` is ignored unless the state is IDLE.
- poi is a POI_AW-bit counter. It wraps to 0 only through IDLE, never mid-scan.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, all outputs 0 (`busy`, `rd_en`, `rd_addr`, `res_*`, `done`). Internal counters are 0 and the accumulator holds 0xFF/0/0.
- Reset asserted mid-scan aborts immediately. No result or `done` is produced. The block restarts only on a new `start`.
- Cycle numbering: `start` sampled high at edge E0; cycle n follows edge n−1.
- First POI:
  - `busy`=1 from cycle 1.
  - `rd_en` high in cycles 1..32.
  - `rd_data` is consumed in cycles 2..33.
  - `res_valid` rises in cycle 34.
- With `res_ready` tied high:
  - Each POI takes 34 cycles. Result k is valid in cycle 34+34k.
  - The last result (k=255, defaults) is in cycle 8704.
  - `done`=1 and `busy`=0 in cycle 8705.
- Back-pressure: each cycle of `res_ready`=0 in EMIT delays all later events by one cycle.

## Test plan
- Reset: hold `reset`=0 → every output is 0. Release with `start`=0 → outputs stay 0 and `rd_en` never rises.
- Single minimum: POI 0 window all 0x40 except 0x03 at (17,9); `res_ready`=1 → cycle 34 shows poi=0, row=17, col=9, min=0x03. Also check the `rd_addr` sequence is 0..31 in cycles 1..32.
- Ties: POI 5 has 0x05 at (4,20), (4,3) and (10,0), all else 0x80 → poi=5, row=4, col=3, min=0x05.
- All 0xFF window → row=0, col=0, min=0xFF. A single 0xFE at (31,31) → row=31, col=31, min=0xFE.
- Back-pressure and `start` while busy:
  - Hold `res_ready`=0 for 10 cycles at the first result → outputs stable, `rd_en`=0 throughout, next POI reads begin the cycle after the handshake.
  - Pulse `start` mid-scan → no effect.
- Full scan and reset abort:
  - Random memory with a golden model → 256 results in POI order 0..255, `done` in cycle 8705.
  - Repeat with `reset` pulsed low at cycle 3000 → outputs immediately 0, no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/residual_scan_if.sv
// Residual-memory read port and per-POI result stream shared by residual_scan
// and its surroundings.
interface residual_scan_if #(
    parameter int POI_AW = 8
) ();
    logic              rd_en;
    logic [POI_AW+4:0] rd_addr;
    logic [255:0]      rd_data;

    logic              res_valid;
    logic              res_ready;
    logic [POI_AW-1:0] res_poi;
    logic [4:0]        res_row;
    logic [4:0]        res_col;
    logic [7:0]        res_min;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output res_valid,
        input  res_ready,
        output res_poi,
        output res_row,
        output res_col,
        output res_min
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  res_valid,
        output res_ready,
        input  res_poi,
        input  res_row,
        input  res_col,
        input  res_min
    );
endinterface

// File: rtl/residual_scan.sv
// Scans the 32x32 residual window of every POI, finds the minimum residual and
// its (row, col), and streams one result per POI.
module residual_scan #(
    parameter int POI_DEPTH = 4,
    parameter int POI_WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    residual_scan_if.master bus
);
    localparam int POI_AW    = POI_DEPTH + POI_WIDTH;
    localparam int TOTAL_POI = 1 << POI_AW;
    localparam logic [POI_AW-1:0] LAST_POI = POI_AW'(TOTAL_POI - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    logic [1:0]        state;
    logic [POI_AW-1:0] poi;
    logic [4:0]        row;
    logic              data_valid;
    logic [4:0]        data_row;
    logic [7:0]        acc_min;
    logic [4:0]        acc_row;
    logic [4:0]        acc_col;
    logic [7:0]        row_min;
    logic [4:0]        row_col;

    // Row reduction: strict less-than keeps the lowest column on ties.
    always_comb begin
        row_min = bus.rd_data[7:0];
        row_col = 5'd0;
        for (int c = 1; c < 32; c++) begin
            if (bus.rd_data[8*c +: 8] < row_min) begin
                row_min = bus.rd_data[8*c +: 8];
                row_col = 5'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            poi        <= '0;
            row        <= '0;
            data_valid <= 1'b0;
            data_row   <= '0;
            acc_min    <= 8'hFF;
            acc_row    <= '0;
            acc_col    <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            data_valid <= (state == READ);
            data_row   <= row;

            // Merge precedes the state case so a reinitialisation takes priority.
            if (data_valid && (row_min < acc_min)) begin
                acc_min <= row_min;
                acc_row <= data_row;
                acc_col <= row_col;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        poi     <= '0;
                        row     <= '0;
                        acc_min <= 8'hFF;
                        acc_row <= '0;
                        acc_col <= '0;
                    end
                end
                READ: begin
                    row <= row + 5'd1;
                    if (row == 5'd31) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (bus.res_ready) begin
                        row     <= '0;
                        acc_min <= 8'hFF;
                        acc_row <= '0;
                        acc_col <= '0;
                        if (poi == LAST_POI) begin
                            state <= IDLE;
                            poi   <= '0;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            poi   <= poi + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign bus.rd_en   = (state == READ);
    assign bus.rd_addr = {poi, row};

    // Result fields are held in registers; gating keeps them at zero outside EMIT.
    assign bus.res_valid = (state == EMIT);
    assign bus.res_poi   = (state == EMIT) ? poi     : '0;
    assign bus.res_row   = (state == EMIT) ? acc_row : '0;
    assign bus.res_col   = (state == EMIT) ? acc_col : '0;
    assign bus.res_min   = (state == EMIT) ? acc_min : '0;
endmodule

// File: tb/tb_residual_scan.sv
// Directed bench for residual_scan: reset, minimum search, ties, back-pressure,
// full scan against a golden model, and reset abort.
module tb_residual_scan;
    localparam int POI_AW = 8;
    localparam int NPOI   = 256;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;

    residual_scan_if #(.POI_AW(POI_AW)) bus ();

    residual_scan #(.POI_DEPTH(4), .POI_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    logic [255:0] mem [0:NPOI*32-1];
    logic [7:0]   g_min [0:NPOI-1];
    logic [4:0]   g_row [0:NPOI-1];
    logic [4:0]   g_col [0:NPOI-1];
    logic [7:0]   got_min [0:NPOI-1];
    logic [4:0]   got_row [0:NPOI-1];
    logic [4:0]   got_col [0:NPOI-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous residual memory, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic fill_window(input int p, input logic [7:0] v);
        for (int r = 0; r < 32; r++) mem[p*32 + r] = {32{v}};
    endtask

    task automatic set_cell(input int p, input int r, input int c, input logic [7:0] v);
        mem[p*32 + r][8*c +: 8] = v;
    endtask

    // Reference: raster order over the window, strict less-than.
    task automatic compute_golden();
        logic [7:0] m;
        logic [7:0] v;
        for (int p = 0; p < NPOI; p++) begin
            m = 8'hFF;
            g_row[p] = 5'd0;
            g_col[p] = 5'd0;
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) begin
                    v = mem[p*32 + r][8*c +: 8];
                    if (v < m) begin
                        m = v;
                        g_row[p] = 5'(r);
                        g_col[p] = 5'(c);
                    end
                end
            end
            g_min[p] = m;
        end
    endtask

    task automatic test_reset();
        logic saw_rd;
        reset = 1'b0;
        start = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({busy, done, bus.rd_en, bus.rd_addr, bus.res_valid, bus.res_poi,
             bus.res_row, bus.res_col, bus.res_min} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b rd_en=%b rd_addr=%0d valid=%b poi=%0d row=%0d col=%0d min=%h, required all 0",
                     busy, done, bus.rd_en, bus.rd_addr, bus.res_valid, bus.res_poi,
                     bus.res_row, bus.res_col, bus.res_min);
        end
        reset = 1'b1;
        saw_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rd_en || busy || bus.res_valid || done) saw_rd = 1'b1;
        end
        n_checks++;
        if (saw_rd !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: activity=%b, required 0", saw_rd);
        end
    endtask

    task automatic test_single_min();
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_cycle1: got %b, required 1", busy);
        end
        for (int k = 1; k <= 32; k++) begin
            n_checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== 13'(k - 1)) begin
                n_fail++;
                $display("[TB] FAIL rd_seq cycle %0d: rd_en=%b addr=%0d, required 1 / %0d",
                         cyc, bus.rd_en, bus.rd_addr, k - 1);
            end
            if (k < 32) step();
        end
        step();
        n_checks++;
        if (bus.rd_en !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_cycle33: rd_en=%b valid=%b, required 0 / 0", bus.rd_en, bus.res_valid);
        end
        step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_poi !== 8'd0 || bus.res_row !== 5'd17 ||
            bus.res_col !== 5'd9 || bus.res_min !== 8'h03) begin
            n_fail++;
            $display("[TB] FAIL single_min cycle34: valid=%b poi=%0d row=%0d col=%0d min=%h, required 1 0 17 9 03",
                     bus.res_valid, bus.res_poi, bus.res_row, bus.res_col, bus.res_min);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.rd_en !== 1'b0 || bus.res_poi !== 8'd0 ||
                bus.res_row !== 5'd17 || bus.res_col !== 5'd9 || bus.res_min !== 8'h03) begin
                n_fail++;
                $display("[TB] FAIL stall cycle %0d: valid=%b rd_en=%b poi=%0d row=%0d col=%0d min=%h, required 1 0 0 17 9 03",
                         cyc, bus.res_valid, bus.rd_en, bus.res_poi, bus.res_row, bus.res_col, bus.res_min);
            end
            step();
        end
        bus.res_ready = 1'b1;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_min !== 8'h03) begin
            n_fail++;
            $display("[TB] FAIL stall_release: valid=%b min=%h, required 1 / 03", bus.res_valid, bus.res_min);
        end
        step();
        n_checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== 13'd32 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL next_poi_read: rd_en=%b addr=%0d valid=%b, required 1 32 0",
                     bus.rd_en, bus.rd_addr, bus.res_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || bus.rd_addr !== 13'd33) begin
            n_fail++;
            $display("[TB] FAIL start_ignored: busy=%b addr=%0d, required 1 / 33", busy, bus.rd_addr);
        end
    endtask

    task automatic test_full_scan();
        int exp_poi;
        int done_cyc;
        exp_poi  = 1;
        done_cyc = -1;
        while (cyc < 9000 && done_cyc < 0) begin
            if (bus.res_valid && exp_poi < NPOI) begin
                got_row[exp_poi] = bus.res_row;
                got_col[exp_poi] = bus.res_col;
                got_min[exp_poi] = bus.res_min;
                n_checks++;
                if (bus.res_poi !== 8'(exp_poi) || bus.res_row !== g_row[exp_poi] ||
                    bus.res_col !== g_col[exp_poi] || bus.res_min !== g_min[exp_poi]) begin
                    n_fail++;
                    $display("[TB] FAIL scan_result %0d: poi=%0d row=%0d col=%0d min=%h, required %0d %0d %0d %h",
                             exp_poi, bus.res_poi, bus.res_row, bus.res_col, bus.res_min,
                             exp_poi, g_row[exp_poi], g_col[exp_poi], g_min[exp_poi]);
                end
                exp_poi++;
            end
            if (done) done_cyc = cyc;
            else step();
        end
        n_checks++;
        if (exp_poi !== NPOI) begin
            n_fail++;
            $display("[TB] FAIL scan_count: got %0d results, required %0d", exp_poi, NPOI);
        end
        n_checks++;
        if (done_cyc !== 8715 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL scan_done: cycle=%0d busy=%b, required 8715 / 0", done_cyc, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_windows();
        n_checks++;
        if (got_row[1] !== 5'd0 || got_col[1] !== 5'd0 || got_min[1] !== 8'hFF) begin
            n_fail++;
            $display("[TB] FAIL all_ff: row=%0d col=%0d min=%h, required 0 0 ff", got_row[1], got_col[1], got_min[1]);
        end
        n_checks++;
        if (got_row[2] !== 5'd31 || got_col[2] !== 5'd31 || got_min[2] !== 8'hFE) begin
            n_fail++;
            $display("[TB] FAIL corner_fe: row=%0d col=%0d min=%h, required 31 31 fe", got_row[2], got_col[2], got_min[2]);
        end
        n_checks++;
        if (got_row[5] !== 5'd4 || got_col[5] !== 5'd3 || got_min[5] !== 8'h05) begin
            n_fail++;
            $display("[TB] FAIL ties: row=%0d col=%0d min=%h, required 4 3 05", got_row[5], got_col[5], got_min[5]);
        end
    endtask

    task automatic test_reset_abort();
        logic activity;
        repeat (3) step();
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 3000) step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, bus.rd_en, bus.rd_addr, bus.res_valid, bus.res_poi,
             bus.res_row, bus.res_col, bus.res_min} !== '0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: busy=%b done=%b rd_en=%b addr=%0d valid=%b min=%h, required all 0",
                     busy, done, bus.rd_en, bus.rd_addr, bus.res_valid, bus.res_min);
        end
        repeat (2) step();
        reset = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done || bus.rd_en || bus.res_valid || busy) activity = 1'b1;
        end
        n_checks++;
        if (activity !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_quiet: activity=%b, required 0", activity);
        end
    endtask

    task automatic test_restart();
        int exp_poi;
        int done_cyc;
        int first_cyc;
        exp_poi   = 0;
        done_cyc  = -1;
        first_cyc = -1;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 9000 && done_cyc < 0) begin
            if (bus.res_valid && exp_poi < NPOI) begin
                if (exp_poi == 0) first_cyc = cyc;
                n_checks++;
                if (bus.res_poi !== 8'(exp_poi) || bus.res_row !== g_row[exp_poi] ||
                    bus.res_col !== g_col[exp_poi] || bus.res_min !== g_min[exp_poi]) begin
                    n_fail++;
                    $display("[TB] FAIL restart_result %0d: poi=%0d row=%0d col=%0d min=%h, required %0d %0d %0d %h",
                             exp_poi, bus.res_poi, bus.res_row, bus.res_col, bus.res_min,
                             exp_poi, g_row[exp_poi], g_col[exp_poi], g_min[exp_poi]);
                end
                exp_poi++;
            end
            if (done) done_cyc = cyc;
            else step();
        end
        n_checks++;
        if (first_cyc !== 34 || exp_poi !== NPOI || done_cyc !== 8705 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL restart_timing: first=%0d count=%0d done=%0d busy=%b, required 34 256 8705 0",
                     first_cyc, exp_poi, done_cyc, busy);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.res_ready = 1'b0;
        for (int p = 0; p < NPOI; p++) begin
            for (int r = 0; r < 32; r++) begin
                mem[p*32 + r] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        fill_window(0, 8'h40);
        set_cell(0, 17, 9, 8'h03);
        fill_window(1, 8'hFF);
        fill_window(2, 8'hFF);
        set_cell(2, 31, 31, 8'hFE);
        fill_window(5, 8'h80);
        set_cell(5, 4, 20, 8'h05);
        set_cell(5, 4, 3, 8'h05);
        set_cell(5, 10, 0, 8'h05);
        compute_golden();

        test_reset();
        test_single_min();
        test_back_pressure();
        test_full_scan();
        test_windows();
        test_reset_abort();
        test_restart();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
